// File: rtl/mod_pkg.sv
// Shared types and sizing helpers for the sequential modulo engine.
package mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mod_state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Bits needed to hold a step counter that runs from w-1 down to 0.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/mod_restore_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, report the quotient bit.
module mod_restore_step
  import mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   partial_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   partial_o,
  output logic             qbit_o
);

  // A stored partial is always below the divisor, so its top bit is zero;
  // the extra bit only matters for the shifted value compared below.
  logic             unused_msb;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   divisor_ext;

  assign unused_msb  = partial_i[WIDTH];
  assign shifted     = {partial_i[WIDTH-1:0], bit_i};
  assign divisor_ext = {1'b0, divisor_i};
  assign qbit_o      = (shifted >= divisor_ext);
  assign partial_o   = qbit_o ? (shifted - divisor_ext) : shifted;

endmodule

// File: rtl/seq_modulo_unit.sv
// Iterative restoring modulo engine: dividend % divisor, one bit per cycle.
// Optional quotient output is enabled by defining MOD_QUOTIENT_EN.
//
// Handshake: a transfer happens on a posedge where valid & ready are both
// high. in_ready is high in IDLE and follows out_ready in DONE, so a result
// can be taken and a new operand accepted on the same edge. out_valid stays
// high, with outputs stable, until the take edge.
module seq_modulo_unit
  import mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div0,
`ifdef MOD_QUOTIENT_EN
  output logic [WIDTH-1:0] out_quot,
`endif
  output mod_state_t       dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  mod_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Dividend shifts out at the top while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;
`ifdef MOD_QUOTIENT_EN
  logic [WIDTH-1:0] quot_q, quot_d;
`else
  logic             unused_qbit;
`endif
  logic [WIDTH:0]   step_part;
  logic             step_qbit;
  logic             accept;
  logic             qbit_in;

  mod_restore_step #(.WIDTH(WIDTH)) u_step (
    .partial_i (part_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .partial_o (step_part),
    .qbit_o    (step_qbit)
  );

`ifdef MOD_QUOTIENT_EN
  assign qbit_in = step_qbit;
`else
  assign qbit_in     = 1'b0;
  assign unused_qbit = step_qbit;
`endif

  // Next-state, handshake and datapath next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    part_d   = part_q;
    rem_d    = rem_q;
    div0_d   = div0_q;
`ifdef MOD_QUOTIENT_EN
    quot_d   = quot_q;
`endif
    in_ready = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      CALC: begin
        part_d = step_part;
        dvd_d  = {dvd_q[WIDTH-2:0], qbit_in};
        if (cnt_q == '0) begin
          state_d = DONE;
          rem_d   = step_part[WIDTH-1:0];
          div0_d  = 1'b0;
`ifdef MOD_QUOTIENT_EN
          quot_d  = {dvd_q[WIDTH-2:0], qbit_in};
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      dvd_d  = in_dividend;
      dsr_d  = in_divisor;
      part_d = '0;
      cnt_d  = CW'(WIDTH - 1);
      if (in_divisor == '0) begin
        state_d = DONE;
        rem_d   = in_dividend;
        div0_d  = 1'b1;
`ifdef MOD_QUOTIENT_EN
        quot_d  = '1;
`endif
      end else begin
        state_d = CALC;
      end
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      part_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
`ifdef MOD_QUOTIENT_EN
      quot_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      part_q  <= part_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
`ifdef MOD_QUOTIENT_EN
      quot_q  <= quot_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_rem   = rem_q;
  assign out_div0  = div0_q;
`ifdef MOD_QUOTIENT_EN
  assign out_quot  = quot_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_modulo_unit.sv
// Self-checking bench for seq_modulo_unit (WIDTH=8); honours MOD_QUOTIENT_EN.
module tb_seq_modulo_unit;
  import mod_pkg::*;

  localparam int W  = 8;
  localparam int EW = 2 * W + 1;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         out_valid;
  wire logic    out_ready;
  logic [W-1:0] out_rem;
  logic         out_div0;
  logic [W-1:0] quot_obs;
  mod_state_t   dbg_state;

  logic         rand_mode;
  logic         rnd_ready;
  logic         ready_cmd;

  int errors;
  int checks;
  logic [EW-1:0] exp_q[$];

  assign out_ready = rand_mode ? rnd_ready : ready_cmd;

  seq_modulo_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rem     (out_rem),
    .out_div0    (out_div0),
`ifdef MOD_QUOTIENT_EN
    .out_quot    (quot_obs),
`endif
    .dbg_state   (dbg_state)
  );

`ifndef MOD_QUOTIENT_EN
  assign quot_obs = '0;
`endif

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random consumer stalls, updated away from the sampling points.
  always @(posedge clock) begin
    #2;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Reference model: {div0, quot, rem}; quotient masked when not built.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    if (b == 0) begin
      z = 1'b1; q = '1; r = a;
    end else begin
      z = 1'b0; q = a / b; r = a % b;
    end
`ifndef MOD_QUOTIENT_EN
    q = '0;
`endif
    return {z, q, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare each result on the cycle it is taken.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        check("result", 32'({out_div0, quot_obs, out_rem}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one operand pair and hold it until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    if (push) exp_q.push_back(model(a, b));
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid    = 1'b0;
    in_dividend = W'($urandom);
    in_divisor  = W'($urandom);
  endtask

  // Count edges (accept edge = 1) until out_valid rises.
  task automatic wait_valid(input int lat, input string tag);
    int n;
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(lat));
  endtask

  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    errors = 0; checks = 0;
    rand_mode = 1'b0; ready_cmd = 1'b1; rnd_ready = 1'b1;
    reset_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
    tick(); tick();
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_rem", 32'(out_rem), 32'd0);
    check("reset_out_div0", 32'(out_div0), 32'd0);
    check("reset_out_quot", 32'(quot_obs), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic results and latency.
    send(8'd200, 8'd14, 1'b1); wait_valid(W + 1, "lat_200_14");
    tick();
    check("valid_drops_after_take", 32'(out_valid), 32'd0);
    send(8'd13, 8'd14, 1'b1);  wait_valid(W + 1, "lat_13_14");
    send(8'd255, 8'd1, 1'b1);  wait_valid(W + 1, "lat_255_1");
    send(8'd255, 8'd128, 1'b1); wait_valid(W + 1, "lat_255_128");
    send(8'd77, 8'd0, 1'b1);   wait_valid(1, "lat_div0");
    tick();

    // Hold result under back-pressure, then take + accept on the same edge.
    ready_cmd = 1'b0;
    send(8'd100, 8'd7, 1'b1); wait_valid(W + 1, "lat_100_7");
    for (int i = 0; i < 20; i++) begin
      in_valid    = 1'b1;
      in_dividend = W'($urandom);
      in_divisor  = W'($urandom);
      tick();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_rem", 32'(out_rem), 32'd2);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    ready_cmd = 1'b1;
    send(8'd50, 8'd6, 1'b1);
    check("b2b_state_calc", 32'(dbg_state), 32'(CALC));
    check("b2b_valid_low", 32'(out_valid), 32'd0);
    wait_valid(W + 1, "lat_50_6");
    tick();

    // Reset in the 4th CALC cycle discards the operation.
    send(8'd200, 8'd3, 1'b0);
    tick(); tick(); tick();
    check("pre_reset_calc", 32'(dbg_state), 32'(CALC));
    reset_n = 1'b0;
    tick();
    check("mid_reset_state", 32'(dbg_state), 32'(IDLE));
    check("mid_reset_valid", 32'(out_valid), 32'd0);
    check("mid_reset_rem", 32'(out_rem), 32'd0);
    check("mid_reset_div0", 32'(out_div0), 32'd0);
    check("mid_reset_quot", 32'(quot_obs), 32'd0);
    reset_n = 1'b1;
    tick();
    send(8'd9, 8'd4, 1'b1); wait_valid(W + 1, "lat_9_4");
    tick();

    // Random operands with random consumer stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 15))
        0:       b = '0;
        1:       b = 8'd1;
        2:       b = 8'h80 | W'($urandom);
        3:       b = 8'hff;
        default: b = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       a = 8'hff;
        1:       a = '0;
        default: a = W'($urandom);
      endcase
      send(a, b, 1'b1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
